i2c_reg_sequencer: RTL
======================

Name: i2c_reg_sequencer

Overview:
Sequences the I2C master to perform complete single-byte register transactions, either a write or a random read, from one request.
- Sits between a register-bus requester and the I2C master.
- Converts {rw, dev_addr, reg_addr, wdata} into the START / WRITE / RESTART / READ / STOP command stream.
- Collects the slave ACKs and returns read data or a NACK error to the requester.

Parameters:
- START_CMD, 3'b000, master start command code
- STOP_CMD, 3'b001, master stop command code
- READ_CMD, 3'b010, master read command code
- WRITE_CMD, 3'b011, master write command code
- RESTART_CMD, 3'b100, master restart command code
- DVSR_DEFAULT, 16'd250, quarter-SCL-period divisor driven on m_dvsr

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high when the sequencer can accept a request (IDLE)
- req_rw  in  1  0=write, 1=read
- req_dev  in  7  7-bit slave address
- req_reg  in  8  register address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  8  read data; 0 for writes and errors
- rsp_nack  out  1  1 = a slave NACKed an address, register or data byte
- m_wr_i2c  out  1  one-cycle command strobe to the master
- m_cmd  out  3  command code
- m_data_in  out  8  byte to transmit; 8'hFF for a read (master NACKs the last byte)
- m_dvsr  out  16  constant DVSR_DEFAULT
- m_ready  in  1  master ready (idle or hold)
- m_done_tick  in  1  master byte-complete level; informational only, not used for sequencing
- m_ack  in  1  last sampled ACK bit (0 = ACK)
- m_data_out  in  8  last received byte

Behaviour:
- Reset values:
  - state IDLE
  - req_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_nack=0
  - m_wr_i2c=0, m_cmd=START_CMD, m_data_in=0
  - step register and captured request cleared
- Accept: in IDLE, req_valid & req_ready captures all req_* fields. req_ready drops the next cycle and stays 0 until return to IDLE.
- Step sequence:
  - Write: START, WR {dev,0}, WR reg, WR wdata, STOP.
  - Read: START, WR {dev,0}, WR reg, RESTART, WR {dev,1}, RD (data 8'hFF), STOP.
- States:
  - IDLE → ISSUE on accept.
  - ISSUE: wait for m_ready=1, then assert m_wr_i2c for exactly 1 cycle with m_cmd/m_data_in of the current step → WAIT_BUSY.
  - WAIT_BUSY: wait for m_ready=0 (the master leaves idle/hold one cycle after the strobe) → WAIT_RDY.
  - WAIT_RDY: wait for m_ready=1.
    - If the step was WR, sample m_ack.
    - If the step was RD, latch m_data_out into rdata.
    - Advance the step → ISSUE, or → RESP after STOP.
  - RESP: rsp_valid=1 for one cycle with rdata/nack → IDLE.
- m_wr_i2c is never asserted outside ISSUE. m_cmd and m_data_in hold their value from the strobe until the next strobe.
- NACK abort: m_ack=1 sampled after any WR step sets the nack flag and jumps the step to STOP. rsp_nack=1, rsp_rdata=0. No further byte is sent.
- Latency, write: 5 master commands plus 3 sequencer cycles per command plus 1 RESP cycle.
- m_done_tick is ignored, so sequencing is immune to its multi-cycle width.
- A new req_valid while busy is not accepted; the requester must hold it until req_ready=1.
- Reset mid-transaction: abandon immediately to reset values. The master shares the reset, so the bus returns to idle; no STOP is issued.
- Widths: the address byte is {req_dev, rw_bit}, with no truncation. rdata is 8 bits.

Test Plan:
- Write dev=0x50 reg=0x10 wdata=0xA5, slave ACKs all → strobes START, WR 0xA0, WR 0x10, WR 0xA5, STOP, each exactly 1 cycle wide. rsp_valid once, rsp_nack=0, rsp_rdata=0x00.
- Read dev=0x50 reg=0x20, slave returns 0x3C → command sequence START, WR 0xA0, WR 0x20, RESTART, WR 0xA1, RD 0xFF, STOP. rsp_rdata=0x3C, rsp_nack=0.
- Write dev=0x33 with no slave (address NACK) → START, WR 0x66, STOP only. rsp_nack=1, rsp_rdata=0x00.
- NACK on the register byte in a read → RESTART is never issued, STOP follows. rsp_nack=1.
- req_valid held high continuously, second request 0x51/0x11 → req_ready=0 throughout the first transaction. The second request is accepted the cycle req_ready returns to 1, with no strobe overlap.
- Assert reset during the WR 0x10 step → next cycle all outputs at reset values, req_ready=1, no rsp_valid. A following request completes normally.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// Turns one register-bus request into the I2C master command stream for a
// single-byte register write or random read, then returns read data or a NACK.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a request; req_ready high
// ISSUE     | wait for master ready, then strobe the current step's command
// WAIT_BUSY | wait for the master to leave idle/hold
// WAIT_RDY  | wait for the step to finish; sample ACK or read data
// RESP      | one-cycle response strobe back to the requester
module i2c_reg_sequencer #(
  parameter logic [2:0]  START_CMD    = 3'b000,
  parameter logic [2:0]  STOP_CMD     = 3'b001,
  parameter logic [2:0]  READ_CMD     = 3'b010,
  parameter logic [2:0]  WRITE_CMD    = 3'b011,
  parameter logic [2:0]  RESTART_CMD  = 3'b100,
  parameter logic [15:0] DVSR_DEFAULT = 16'd250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [6:0]  req_dev,
  input  logic [7:0]  req_reg,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_nack,
  output logic        m_wr_i2c,
  output logic [2:0]  m_cmd,
  output logic [7:0]  m_data_in,
  output logic [15:0] m_dvsr,
  input  logic        m_ready,
  input  logic        m_done_tick,
  input  logic        m_ack,
  input  logic [7:0]  m_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_RDY,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    ST_START,
    ST_WR_DEV,
    ST_WR_REG,
    ST_WR_DATA,
    ST_RESTART,
    ST_WR_DEV_RD,
    ST_RD,
    ST_STOP
  } step_t;

  state_t      state_q, state_d;
  step_t       step_q, step_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        nack_q, nack_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [7:0]  data_q, data_d;
  logic        strobe;
  logic [2:0]  step_cmd;
  logic [7:0]  step_data;
  logic        step_is_wr;
  step_t       step_next;

  // Byte-complete timing comes from m_ready alone, so the tick is not needed.
  logic unused_done_tick;
  assign unused_done_tick = m_done_tick;

  always_comb begin
    step_cmd   = START_CMD;
    step_data  = 8'h00;
    step_is_wr = 1'b0;
    step_next  = ST_STOP;
    case (step_q)
      ST_START: begin
        step_cmd  = START_CMD;
        step_next = ST_WR_DEV;
      end
      ST_WR_DEV: begin
        step_cmd   = WRITE_CMD;
        step_data  = {dev_q, 1'b0};
        step_is_wr = 1'b1;
        step_next  = ST_WR_REG;
      end
      ST_WR_REG: begin
        step_cmd   = WRITE_CMD;
        step_data  = reg_q;
        step_is_wr = 1'b1;
        step_next  = rw_q ? ST_RESTART : ST_WR_DATA;
      end
      ST_WR_DATA: begin
        step_cmd   = WRITE_CMD;
        step_data  = wdata_q;
        step_is_wr = 1'b1;
        step_next  = ST_STOP;
      end
      ST_RESTART: begin
        step_cmd  = RESTART_CMD;
        step_next = ST_WR_DEV_RD;
      end
      ST_WR_DEV_RD: begin
        step_cmd   = WRITE_CMD;
        step_data  = {dev_q, 1'b1};
        step_is_wr = 1'b1;
        step_next  = ST_RD;
      end
      ST_RD: begin
        step_cmd  = READ_CMD;
        step_data = 8'hFF;
        step_next = ST_STOP;
      end
      default: begin
        step_cmd  = STOP_CMD;
        step_next = ST_STOP;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    strobe  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          rdata_d = 8'h00;
          nack_d  = 1'b0;
          step_d  = ST_START;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_ready) begin
          strobe  = 1'b1;
          cmd_d   = step_cmd;
          data_d  = step_data;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!m_ready) state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (m_ready) begin
          if (step_q == ST_STOP) begin
            state_d = S_RESP;
          end else if (step_is_wr && m_ack) begin
            // Any NACK aborts straight to STOP; no further byte goes out.
            nack_d  = 1'b1;
            step_d  = ST_STOP;
            state_d = S_ISSUE;
          end else begin
            if (step_q == ST_RD) rdata_d = m_data_out;
            step_d  = step_next;
            state_d = S_ISSUE;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= ST_START;
      rw_q    <= 1'b0;
      dev_q   <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      nack_q  <= 1'b0;
      cmd_q   <= START_CMD;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
    end
  end

  // Command fields present the new step during its strobe, then hold.
  assign m_wr_i2c  = strobe;
  assign m_cmd     = strobe ? step_cmd : cmd_q;
  assign m_data_in = strobe ? step_data : data_q;
  assign m_dvsr    = DVSR_DEFAULT;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_nack  = rsp_valid & nack_q;
  assign rsp_rdata = (rsp_valid && !nack_q) ? rdata_q : 8'h00;

endmodule
